pkt_loader: RTL and testbench
=============================

Name: pkt_loader

Overview:
Ingress sequencer for the 128-byte packet buffer. It accepts a packet as a stream of 64-bit beats over a valid/ready handshake and assembles them into a 1024-bit image. It then pulses the buffer's load strobe and hands the packet to the core with a start pulse. It holds off further ingress until the core signals done, so the buffer is never overwritten while the core is reading it.

Parameters:
DATA_W, 64, beat width in bits
NUM_BEATS, 16, beats per buffer image (16 x 64 = 1024 bits = 128 bytes)
CNT_W, 32, width of the completed-packet counter
(derived localparam BUF_W = DATA_W*NUM_BEATS; BEAT_IDX_W = clog2(NUM_BEATS)+1)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
s_valid  input  1  ingress beat valid
s_ready  output  1  ingress beat ready
s_data  input  DATA_W  ingress beat payload
s_last  input  1  marks the final beat of a packet
buf_load  output  1  one-cycle load strobe to the packet buffer
buf_data  output  BUF_W  assembled image, driven from a register
core_start  output  1  one-cycle pulse: packet available to the core
core_done  input  1  core has finished with the current packet
pkt_beats  output  BEAT_IDX_W  beats stored for the current packet (1..NUM_BEATS)
pkt_trunc  output  1  current packet exceeded NUM_BEATS; excess beats dropped
pkt_count  output  CNT_W  completed packets (core_done accepted)

Behaviour:
- A beat is accepted when s_valid & s_ready are high at a rising edge of clk.
- Beat k (0-based) is written to buf_data[DATA_W*k +: DATA_W]. Beat 0 occupies the low bits.
- States:
  - IDLE: s_ready=1. On an accepted beat: zero lanes 1..NUM_BEATS-1, write lane 0, pkt_beats=1, pkt_trunc=0. If s_last, go to LOAD; otherwise go to FILL.
  - FILL: s_ready=1. Each accepted beat writes lane pkt_beats, then pkt_beats increments.
    - If s_last, go to LOAD.
    - Else if this beat filled lane NUM_BEATS-1, set pkt_trunc=1 and go to DRAIN.
  - DRAIN: s_ready=1. Accepted beats are discarded. On an accepted beat with s_last, go to LOAD.
  - LOAD: s_ready=0, buf_load=1 for exactly one cycle, buf_data stable. Next state START.
  - START: s_ready=0, core_start=1 for exactly one cycle. Next state WAIT.
  - WAIT: s_ready=0. On core_done, increment pkt_count (wraps modulo 2^CNT_W) and go to IDLE.
- core_done is ignored in every state except WAIT, including the START cycle.
- Latency: last beat accepted at edge N; buf_load is high in the cycle after N and core_start in the cycle after that. If core_done is sampled at edge M in WAIT, s_ready is high in the cycle after M.
- Short packet (s_last before NUM_BEATS beats): unfilled lanes remain zero.
- Exactly NUM_BEATS beats with s_last on the final beat: goes to LOAD with pkt_trunc=0, not DRAIN.
- Overlong packet: the first NUM_BEATS beats are kept, pkt_beats saturates at NUM_BEATS, pkt_trunc=1 until the next packet starts.
- A beat with s_valid=0 in FILL/DRAIN is a stall: no state change.
- buf_data, pkt_beats and pkt_trunc hold their values from LOAD through WAIT and IDLE until the next packet's first beat.
- Reset (any state, including mid-FILL or WAIT): state=IDLE, s_ready=1 from the first cycle after reset, buf_load=0, core_start=0, buf_data=0, pkt_beats=0, pkt_trunc=0, pkt_count=0. A partial packet is discarded; upstream restarts on a packet boundary.
- All outputs are registered, except s_ready, which is decoded from state only. There is no combinational path from s_valid to s_ready.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, FILL, DRAIN, LOAD, START, WAIT
  - PKT_BEATS = 16 and PKT_BYTES = 128, shared with the packet buffer so sizes cannot diverge
- One natural sub-module: pkt_assembler. It holds the lane register, lane write-enable decode, clear-on-first-beat and the beat counter with saturation.
- The FSM, handshake and pkt_count stay in pkt_loader.

Test Plan:
- Full packet: 16 beats, s_data=64'h1000+k, s_last on k=15 -> one buf_load pulse; lane k = 64'h1000+k; pkt_beats=16; pkt_trunc=0; core_start one cycle later; s_ready=0 until core_done.
- Short packet: 3 beats, AA.., BB.., CC.. then s_last -> lanes 0-2 hold data, lanes 3-15 = 0, pkt_beats=3. A prior full packet's data must not leak into lanes 3-15.
- Overlong packet: 20 beats -> lanes hold beats 0-15, beats 16-19 accepted and dropped, pkt_trunc=1, buf_load only after beat 19 (s_last).
- Single-beat packet with s_valid stalls inserted, then core_done held high for 5 cycles in WAIT -> pkt_count increments once, to 1. core_done asserted during LOAD/START has no effect.
- Back-to-back: 3 packets with core_done one cycle after each core_start -> pkt_count=3; each packet's first beat accepted the cycle after core_done.
- Reset mid-FILL after 7 beats -> all outputs at reset values next cycle. A new 2-beat packet then loads cleanly with pkt_beats=2 and lanes 2-15 = 0.

Source files
------------

// File: rtl/pkt_loader_pkg.sv
// pkt_loader_pkg: definitions shared by the packet ingress sequencer and the packet buffer.
//   PKT_BEATS / PKT_BYTES : buffer geometry, the single source for both sides
//   state_e               : sequencer state encoding
package pkt_loader_pkg;

    localparam int unsigned PKT_BEATS = 16;
    localparam int unsigned PKT_BYTES = 128;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StDrain,
        StLoad,
        StStart,
        StWait
    } state_e;

endpackage

// File: rtl/pkt_loader_if.sv
// pkt_loader_if: bundle of the ingress stream, buffer load and core handshake signals.
//   s_valid/s_ready/s_data/s_last : ingress beat stream
//   buf_load/buf_data             : load strobe and assembled image to the packet buffer
//   core_start/core_done          : packet hand-off to and release from the core
//   pkt_beats/pkt_trunc/pkt_count : status of the current packet and completed-packet count
// Modports: slave = the loader itself, master = its environment (upstream, buffer, core).
interface pkt_loader_if import pkt_loader_pkg::*; #(
    parameter int unsigned DATA_W    = PKT_BYTES * 8 / PKT_BEATS,
    parameter int unsigned NUM_BEATS = PKT_BEATS,
    parameter int unsigned CNT_W     = 32
);
    localparam int unsigned BUF_W      = DATA_W * NUM_BEATS;
    localparam int unsigned BEAT_IDX_W = $clog2(NUM_BEATS) + 1;

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic                  s_last;
    logic                  buf_load;
    logic [BUF_W-1:0]      buf_data;
    logic                  core_start;
    logic                  core_done;
    logic [BEAT_IDX_W-1:0] pkt_beats;
    logic                  pkt_trunc;
    logic [CNT_W-1:0]      pkt_count;

    modport slave (
        input  s_valid, s_data, s_last, core_done,
        output s_ready, buf_load, buf_data, core_start, pkt_beats, pkt_trunc, pkt_count
    );

    modport master (
        output s_valid, s_data, s_last, core_done,
        input  s_ready, buf_load, buf_data, core_start, pkt_beats, pkt_trunc, pkt_count
    );

endinterface

// File: rtl/pkt_assembler.sv
// pkt_assembler: lane register that assembles ingress beats into one buffer image.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : store wr_data into the next lane (accepted beat in IDLE or FILL)
//   first      : this beat starts a new packet (clears lanes, restarts counter)
//   last       : the beat carries s_last
//   wr_data    : beat payload
//   buf_data   : assembled image (registered)
//   beats      : lanes written for the current packet, saturating at NUM_BEATS
//   trunc      : packet filled every lane without s_last
//   last_lane  : the next write lands in lane NUM_BEATS-1
module pkt_assembler import pkt_loader_pkg::*; #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_BEATS = PKT_BEATS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic                                 first,
    input  logic                                 last,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W*NUM_BEATS-1:0]          buf_data,
    output logic [$clog2(NUM_BEATS):0]           beats,
    output logic                                 trunc,
    output logic                                 last_lane
);
    localparam int unsigned BUF_W      = DATA_W * NUM_BEATS;
    localparam int unsigned BEAT_IDX_W = $clog2(NUM_BEATS) + 1;
    localparam logic [BEAT_IDX_W-1:0] LAST_LANE = BEAT_IDX_W'(NUM_BEATS - 1);
    localparam logic [BEAT_IDX_W-1:0] FULL_CNT  = BEAT_IDX_W'(NUM_BEATS);

    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [BEAT_IDX_W-1:0] beats_q, beats_d;
    logic                  trunc_q, trunc_d;
    logic [BEAT_IDX_W-1:0] lane_idx;
    logic [NUM_BEATS-1:0]  lane_we;

    // A saturated counter matches no lane, so nothing past the last lane is written.
    assign lane_idx  = first ? '0 : beats_q;
    assign last_lane = (beats_q == LAST_LANE);

    always_comb begin
        lane_we = '0;
        for (int k = 0; k < NUM_BEATS; k++) begin
            lane_we[k] = wr_en && (lane_idx == BEAT_IDX_W'(k));
        end
    end

    always_comb begin
        buf_d   = (wr_en && first) ? '0 : buf_q;
        beats_d = beats_q;
        trunc_d = trunc_q;
        for (int k = 0; k < NUM_BEATS; k++) begin
            if (lane_we[k]) begin
                buf_d[k*DATA_W +: DATA_W] = wr_data;
            end
        end
        if (wr_en) begin
            if (first) begin
                beats_d = BEAT_IDX_W'(1);
                trunc_d = 1'b0;
            end else if (beats_q != FULL_CNT) begin
                beats_d = beats_q + BEAT_IDX_W'(1);
                if (!last && beats_q == LAST_LANE) begin
                    trunc_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            beats_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            beats_q <= beats_d;
            trunc_q <= trunc_d;
        end
    end

    assign buf_data = buf_q;
    assign beats    = beats_q;
    assign trunc    = trunc_q;

endmodule

// File: rtl/pkt_loader.sv
// pkt_loader: ingress sequencer for the packet buffer. Collects a packet of beats, pulses
// the buffer load strobe, starts the core and blocks ingress until the core is done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pkt_loader_if slave port (ingress stream, buffer load, core handshake, status)
module pkt_loader import pkt_loader_pkg::*; #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NUM_BEATS = PKT_BEATS,
    parameter int unsigned CNT_W     = 32
) (
    input  logic       clk,
    input  logic       rst,
    pkt_loader_if.slave bus
);
    state_e           state_q, state_d;
    logic             accept;
    logic             wr_en;
    logic             first;
    logic             last_lane;
    logic             buf_load_q;
    logic             core_start_q;
    logic [CNT_W-1:0] pkt_count_q;

    // Ready depends on state only, never on s_valid.
    assign bus.s_ready = (state_q == StIdle) || (state_q == StFill) || (state_q == StDrain);
    assign accept      = bus.s_valid && bus.s_ready;
    assign first       = (state_q == StIdle);
    assign wr_en       = accept && ((state_q == StIdle) || (state_q == StFill));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = bus.s_last ? StLoad : StFill;
                end
            end
            StFill: begin
                if (accept) begin
                    if (bus.s_last) begin
                        state_d = StLoad;
                    end else if (last_lane) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (accept && bus.s_last) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StStart;
            StStart: state_d = StWait;
            StWait: begin
                if (bus.core_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            buf_load_q   <= 1'b0;
            core_start_q <= 1'b0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            // Strobes are registered copies of the state being entered.
            buf_load_q   <= (state_d == StLoad);
            core_start_q <= (state_d == StStart);
            if (state_q == StWait && bus.core_done) begin
                pkt_count_q <= pkt_count_q + CNT_W'(1);
            end
        end
    end

    pkt_assembler #(
        .DATA_W    (DATA_W),
        .NUM_BEATS (NUM_BEATS)
    ) u_assembler (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .first     (first),
        .last      (bus.s_last),
        .wr_data   (bus.s_data),
        .buf_data  (bus.buf_data),
        .beats     (bus.pkt_beats),
        .trunc     (bus.pkt_trunc),
        .last_lane (last_lane)
    );

    assign bus.buf_load   = buf_load_q;
    assign bus.core_start = core_start_q;
    assign bus.pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_pkt_loader.sv
// tb_pkt_loader: directed and randomized packets checked against a packet-level model
// (expected image = first NUM_BEATS beats, rest zero; beats = min(n, NUM_BEATS)).
module tb_pkt_loader;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned NUM_BEATS = 16;
    localparam int unsigned CNT_W     = 32;
    localparam int unsigned BUF_W     = DATA_W * NUM_BEATS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_loader_if #(.DATA_W(DATA_W), .NUM_BEATS(NUM_BEATS), .CNT_W(CNT_W)) bus ();

    pkt_loader #(
        .DATA_W    (DATA_W),
        .NUM_BEATS (NUM_BEATS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned       n_checks  = 0;
    int unsigned       n_errors  = 0;
    int unsigned       exp_count = 0;
    logic [DATA_W-1:0] beat_q[$];

    task automatic chk_w(input string tag, input logic [BUF_W-1:0] got,
                         input logic [BUF_W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [BUF_W-1:0] exp_image();
        logic [BUF_W-1:0] img = '0;
        for (int i = 0; i < beat_q.size() && i < NUM_BEATS; i++) begin
            img[i*DATA_W +: DATA_W] = beat_q[i];
        end
        return img;
    endfunction

    function automatic int unsigned exp_beats();
        return (beat_q.size() > NUM_BEATS) ? NUM_BEATS : beat_q.size();
    endfunction

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.core_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        chk_b("rst_ready", bus.s_ready, 1'b1);
        chk_b("rst_load", bus.buf_load, 1'b0);
        chk_b("rst_start", bus.core_start, 1'b0);
        chk_w("rst_data", bus.buf_data, '0);
        chk_w("rst_beats", BUF_W'(bus.pkt_beats), '0);
        chk_b("rst_trunc", bus.pkt_trunc, 1'b0);
        chk_w("rst_count", BUF_W'(bus.pkt_count), '0);
    endtask

    // Presents beat_q[0..n-1] starting at a negedge; returns at the negedge after the last edge.
    task automatic send_pkt(input int n, input bit stall, input bit with_last);
        int s;
        for (int i = 0; i < n; i++) begin
            s = stall ? int'($urandom_range(0, 2)) : 0;
            repeat (s) begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'($urandom_range(0, 1));
                bus.s_data  = {$urandom, $urandom};
                @(negedge clk);
                chk_b("stall_ready", bus.s_ready, 1'b1);
            end
            bus.s_valid = 1'b1;
            bus.s_data  = beat_q[i];
            bus.s_last  = with_last && (i == n - 1);
            chk_b("beat_ready", bus.s_ready, 1'b1);
            chk_b("no_early_load", bus.buf_load, 1'b0);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic check_load(input bit early_done);
        chk_b("load_strobe", bus.buf_load, 1'b1);
        chk_b("load_no_start", bus.core_start, 1'b0);
        chk_b("load_ready", bus.s_ready, 1'b0);
        chk_w("buf_data", bus.buf_data, exp_image());
        chk_w("pkt_beats", BUF_W'(bus.pkt_beats), BUF_W'(exp_beats()));
        chk_b("pkt_trunc", bus.pkt_trunc, beat_q.size() > NUM_BEATS);
        if (early_done) bus.core_done = 1'b1;
        @(negedge clk);
        chk_b("start_pulse", bus.core_start, 1'b1);
        chk_b("start_no_load", bus.buf_load, 1'b0);
        chk_b("start_ready", bus.s_ready, 1'b0);
    endtask

    task automatic finish_pkt(input int wait_cycles, input int hold);
        @(negedge clk);
        bus.core_done = 1'b0;
        chk_b("wait_ready", bus.s_ready, 1'b0);
        chk_b("start_once", bus.core_start, 1'b0);
        chk_w("wait_count", BUF_W'(bus.pkt_count), BUF_W'(exp_count));
        repeat (wait_cycles) begin
            @(negedge clk);
            chk_b("wait_ready", bus.s_ready, 1'b0);
            chk_w("wait_count", BUF_W'(bus.pkt_count), BUF_W'(exp_count));
        end
        bus.core_done = 1'b1;
        @(negedge clk);
        exp_count++;
        chk_b("done_ready", bus.s_ready, 1'b1);
        chk_w("pkt_count", BUF_W'(bus.pkt_count), BUF_W'(exp_count));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk_b("idle_ready", bus.s_ready, 1'b1);
            chk_w("count_once", BUF_W'(bus.pkt_count), BUF_W'(exp_count));
        end
        bus.core_done = 1'b0;
        chk_w("hold_data", bus.buf_data, exp_image());
    endtask

    task automatic run_pkt(input bit stall, input bit early, input int wait_cycles,
                           input int hold);
        send_pkt(beat_q.size(), stall, 1'b1);
        check_load(early);
        finish_pkt(wait_cycles, hold);
    endtask

    task automatic fill_random(input int n);
        beat_q.delete();
        for (int i = 0; i < n; i++) beat_q.push_back({$urandom, $urandom});
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.core_done = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Full 16-beat packet.
        beat_q.delete();
        for (int k = 0; k < NUM_BEATS; k++) beat_q.push_back(DATA_W'(64'h1000 + k));
        run_pkt(1'b0, 1'b0, 2, 1);

        // Short packet after a full one: upper lanes must be cleared.
        beat_q.delete();
        beat_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
        beat_q.push_back(64'hBBBB_BBBB_BBBB_BBBB);
        beat_q.push_back(64'hCCCC_CCCC_CCCC_CCCC);
        run_pkt(1'b0, 1'b0, 1, 1);

        // Overlong packet: 20 beats, last 4 dropped.
        fill_random(20);
        run_pkt(1'b0, 1'b0, 0, 1);

        // Single beat with stalls, core_done during LOAD/START then held 5 cycles.
        do_reset();
        fill_random(1);
        run_pkt(1'b1, 1'b1, 1, 5);
        chk_w("single_count", BUF_W'(bus.pkt_count), BUF_W'(1));

        // Back-to-back packets.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            fill_random(int'($urandom_range(1, NUM_BEATS)));
            run_pkt(1'b0, 1'b0, 0, 1);
        end
        chk_w("b2b_count", BUF_W'(bus.pkt_count), BUF_W'(3));

        // Reset mid-FILL, then a clean 2-beat packet.
        fill_random(7);
        send_pkt(7, 1'b0, 1'b0);
        do_reset();
        fill_random(2);
        run_pkt(1'b0, 1'b0, 0, 1);

        // Randomized packets, including exact, short and overlong lengths.
        for (int p = 0; p < 8; p++) begin
            fill_random(int'($urandom_range(1, NUM_BEATS + 8)));
            run_pkt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
